// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode and FSM state types for the multiply/divide unit
package mips_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } mdu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_DONE
   } mdu_state_t;

   function automatic logic op_is_signed(mdu_op_t op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/mdu_div_core.sv
// rtl/mdu_div_core.sv - restoring unsigned divide datapath, one quotient bit per enable
module mdu_div_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quo_next,
   output logic [WIDTH-1:0] rem_next
);

   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvsr;
   logic [WIDTH:0]   trial;

   // quo holds the not-yet-consumed dividend bits at the top and the quotient bits at the bottom
   always_comb begin
      trial = {rem, quo[WIDTH-1]} - {1'b0, dvsr};
      if (trial[WIDTH]) begin
         rem_next = {rem[WIDTH-2:0], quo[WIDTH-1]};
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end else begin
         rem_next = trial[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem  <= '0;
         quo  <= '0;
         dvsr <= '0;
      end else if (load) begin
         rem  <= '0;
         quo  <= dividend;
         dvsr <= divisor;
      end else if (en) begin
         rem  <= rem_next;
         quo  <= quo_next;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MIPS-style HI/LO multiply/divide unit
// MDU_FAST_MUL_EN: single-cycle multiply at acceptance; divide stays iterative.
module mult_div_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  mdu_op_t          op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   mdu_state_t state, state_next;

   logic [CNT_W-1:0]   cnt;
   logic               last_step;
   logic               accept;
   logic               is_div_op;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               neg_q, neg_r;
   logic [WIDTH-1:0]   dividend_reg;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_step;
   logic [2*WIDTH-1:0] prod_res;
   logic [WIDTH-1:0]   quo_next, rem_next;
   logic [WIDTH-1:0]   quo_res, rem_res;

   assign accept    = start && (state == ST_IDLE);
   assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
   assign last_step = (cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      a_neg = op_is_signed(op) & operand_a[WIDTH-1];
      b_neg = op_is_signed(op) & operand_b[WIDTH-1];
      a_mag = a_neg ? -operand_a : operand_a;
      b_mag = b_neg ? -operand_b : operand_b;
   end

   // shift-add: the multiplier sits in the low half of prod and is shifted out as the product grows
   always_comb begin
      mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
      prod_step = {mul_sum, prod[WIDTH-1:1]};
      prod_res  = neg_q ? -prod_step : prod_step;
   end

`ifdef MDU_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_mag;
   logic [2*WIDTH-1:0] fast_res;
   always_comb begin
      fast_mag = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
      fast_res = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
   end
`endif

   mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
      .clk      (clk),
      .rst      (rst),
      .load     (accept && is_div_op),
      .en       (state == ST_DIV),
      .dividend (a_mag),
      .divisor  (b_mag),
      .quo_next (quo_next),
      .rem_next (rem_next)
   );

   // a zero divisor leaves the raw dividend as remainder regardless of signedness
   always_comb begin
      quo_res = div_by_zero ? '1 : (neg_q ? -quo_next : quo_next);
      rem_res = div_by_zero ? dividend_reg : (neg_r ? -rem_next : rem_next);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               case (op)
`ifdef MDU_FAST_MUL_EN
                  OP_MULT, OP_MULTU: state_next = ST_DONE;
`else
                  OP_MULT, OP_MULTU: state_next = ST_MUL;
`endif
                  OP_DIV, OP_DIVU:   state_next = ST_DIV;
                  default:           state_next = ST_IDLE;
               endcase
            end
         end
         ST_MUL: begin
            busy = 1'b1;
            if (last_step) state_next = ST_DONE;
         end
         ST_DIV: begin
            busy = 1'b1;
            if (last_step) state_next = ST_DONE;
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi           <= '0;
         lo           <= '0;
         div_by_zero  <= 1'b0;
         cnt          <= '0;
         neg_q        <= 1'b0;
         neg_r        <= 1'b0;
         dividend_reg <= '0;
         mcand        <= '0;
         prod         <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cnt <= '0;
                  case (op)
                     OP_MTHI: hi <= operand_a;
                     OP_MTLO: lo <= operand_a;
                     OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MUL_EN
                        {hi, lo} <= fast_res;
`else
                        mcand <= a_mag;
                        prod  <= {{WIDTH{1'b0}}, b_mag};
                        neg_q <= a_neg ^ b_neg;
`endif
                     end
                     OP_DIV, OP_DIVU: begin
                        neg_q        <= a_neg ^ b_neg;
                        neg_r        <= a_neg;
                        dividend_reg <= operand_a;
                        div_by_zero  <= (operand_b == '0);
                     end
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               cnt  <= cnt + CNT_W'(1);
               prod <= prod_step;
               if (last_step) {hi, lo} <= prod_res;
            end
            ST_DIV: begin
               cnt <= cnt + CNT_W'(1);
               if (last_step) begin
                  hi <= rem_res;
                  lo <= quo_res;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit (WIDTH=32)
module tb_mult_div_unit;
   import mips_pkg::*;

   localparam int W = 32;

`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 0;
`else
   localparam int MUL_LAT = W;
`endif
   localparam int DIV_LAT = W;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   mdu_op_t       op;
   logic [W-1:0]  operand_a, operand_b;
   logic          busy, done, div_by_zero;
   logic [W-1:0]  hi, lo;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           cyc;
      string        name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // monitor: every done pulse must match the oldest outstanding expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk({e.name, "_hi"},  64'(hi), 64'(e.hi));
               chk({e.name, "_lo"},  64'(lo), 64'(e.lo));
               chk({e.name, "_dz"},  64'(div_by_zero), 64'(e.dz));
               chk({e.name, "_cyc"}, 64'(cyc), 64'(e.cyc));
            end
         end
      end
   end

   task automatic issue(input mdu_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                        input int lat, input string nm, input bit push);
      exp_t e;
      @(negedge clk);
      if (push) begin
         e.hi = ehi; e.lo = elo; e.dz = edz; e.cyc = cyc + 1 + lat; e.name = nm;
         sb.push_back(e);
      end
      start = 1'b1; op = o; operand_a = a; operand_b = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while ((busy || done || sb.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_timeout"}, 64'(n >= 200), 64'd0);
   endtask

   task automatic run_op(input mdu_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                         input int lat, input string nm);
      issue(o, a, b, ehi, elo, edz, lat, nm, 1'b1);
      wait_idle(nm);
   endtask

   task automatic run_mt(input mdu_op_t o, input logic [W-1:0] a, input string nm);
      @(negedge clk);
      start = 1'b1; op = o; operand_a = a; operand_b = '0;
      @(negedge clk);
      start = 1'b0;
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_done"}, 64'(done), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      mdu_op_t   long_op;
      logic [W-1:0] long_lo;
      int long_lat;
`ifdef MDU_FAST_MUL_EN
      long_op = OP_DIVU; long_lo = 32'd6;   long_lat = DIV_LAT;
`else
      long_op = OP_MULT; long_lo = 32'd150; long_lat = MUL_LAT;
`endif
      rst = 1'b1; start = 1'b0; op = OP_MTHI; operand_a = '0; operand_b = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_hi",   64'(hi), 64'd0);
      chk("reset_lo",   64'(lo), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_dz",   64'(div_by_zero), 64'd0);

      run_mt(OP_MTHI, 32'h1234, "mthi");
      chk("mthi_hi", 64'(hi), 64'h1234);
      run_mt(OP_MTLO, 32'h5678, "mtlo");
      chk("mtlo_lo", 64'(lo), 64'h5678);
      chk("mtlo_hi", 64'(hi), 64'h1234);

      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, MUL_LAT, "multu_max");
      run_op(OP_MULT,  -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, MUL_LAT, "mult_neg");

      // previous result must stay visible while the divide is running
      issue(OP_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_LAT, "div_neg", 1'b1);
      repeat (8) @(negedge clk);
      chk("div_mid_busy", 64'(busy), 64'd1);
      chk("div_mid_hi",   64'(hi), 64'hFFFF_FFFF);
      chk("div_mid_lo",   64'(lo), 64'hFFFF_FFEB);
      wait_idle("div_neg");

      run_op(OP_DIV,   32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, DIV_LAT, "div_negdivisor");
      run_op(OP_DIVU,  32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, DIV_LAT, "divu_zero");
      run_op(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, MUL_LAT, "multu_small");
      run_op(OP_DIV,   -32'sd5, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, DIV_LAT, "div_zero_signed");
      run_op(OP_DIVU,  32'd9, 32'd3, 32'd0, 32'd3, 1'b0, DIV_LAT, "divu_clear");
      run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, DIV_LAT, "div_ovf");

      // a second start while busy is ignored
      issue(long_op, 32'd30, 32'd5, 32'd0, long_lo, 1'b0, long_lat, "long_op", 1'b1);
      repeat (3) @(negedge clk);
      start = 1'b1; op = OP_DIV; operand_a = 32'd100; operand_b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      wait_idle("long_op");
      repeat (40) @(negedge clk);
      chk("ignored_queue", 64'(sb.size()), 64'd0);

      // reset in flight: no done, registers cleared, start loses to rst
      issue(long_op, 32'd30, 32'd5, 32'd0, 32'd0, 1'b0, 0, "abort", 1'b0);
      repeat (8) @(negedge clk);
      rst = 1'b1; start = 1'b1; op = OP_MTHI; operand_a = 32'hDEAD;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      chk("abort_hi",   64'(hi), 64'd0);
      chk("abort_lo",   64'(lo), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_dz",   64'(div_by_zero), 64'd0);
      repeat (40) @(negedge clk);
      rst = 1'b1; start = 1'b1; op = OP_MTHI; operand_a = 32'hBEEF;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      chk("rst_priority_hi", 64'(hi), 64'd0);
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
